// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register: captures EX-stage results and control for the MEM stage,
// with stall (hold), flush (bubble) and the registered branch-taken select for fetch.
module ex_mem_latch #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [1:0]        wb_in,
  input  logic [2:0]        m_in,
  input  logic [DATA_W-1:0] add_result_in,
  input  logic              zero_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] rdata2_in,
  input  logic [REG_W-1:0]  muxout_in,
  output logic              valid_out,
  output logic [1:0]        wb_out,
  output logic              branch_out,
  output logic              memread_out,
  output logic              memwrite_out,
  output logic [DATA_W-1:0] add_result_out,
  output logic              zero_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] rdata2_out,
  output logic [REG_W-1:0]  muxout_out,
  output logic              pcsrc
);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      // Reset and flush both leave a fully zeroed bubble; reset simply wins by
      // appearing in the same branch, and both override a simultaneous stall.
      valid_out      <= 1'b0;
      wb_out         <= '0;
      branch_out     <= 1'b0;
      memread_out    <= 1'b0;
      memwrite_out   <= 1'b0;
      add_result_out <= '0;
      zero_out       <= 1'b0;
      alu_result_out <= '0;
      rdata2_out     <= '0;
      muxout_out     <= '0;
    end else if (!stall) begin
      // Control from an invalid slot is forced to zero so garbage or X on
      // wb_in/m_in can never trigger a register or memory write downstream.
      valid_out      <= valid_in;
      wb_out         <= valid_in ? wb_in   : 2'b00;
      branch_out     <= valid_in ? m_in[2] : 1'b0;
      memread_out    <= valid_in ? m_in[1] : 1'b0;
      memwrite_out   <= valid_in ? m_in[0] : 1'b0;
      add_result_out <= add_result_in;
      zero_out       <= zero_in;
      alu_result_out <= alu_result_in;
      rdata2_out     <= rdata2_in;
      muxout_out     <= muxout_in;
    end
  end

  // Derived purely from registers, so it holds through a stall with the instruction.
  assign pcsrc = branch_out & zero_out & valid_out;

endmodule

// File: tb/tb_ex_mem_latch.sv
// Directed self-checking bench for ex_mem_latch: reset, load, branch, stall,
// flush-over-stall, invalid-control gating and X suppression.
module tb_ex_mem_latch;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic              clk = 1'b0;
  logic              rst, stall, flush, valid_in, zero_in;
  logic [1:0]        wb_in;
  logic [2:0]        m_in;
  logic [DATA_W-1:0] add_result_in, alu_result_in, rdata2_in;
  logic [REG_W-1:0]  muxout_in;
  logic              valid_out, branch_out, memread_out, memwrite_out, zero_out, pcsrc;
  logic [1:0]        wb_out;
  logic [DATA_W-1:0] add_result_out, alu_result_out, rdata2_out;
  logic [REG_W-1:0]  muxout_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_latch #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .valid_in(valid_in), .wb_in(wb_in), .m_in(m_in),
    .add_result_in(add_result_in), .zero_in(zero_in),
    .alu_result_in(alu_result_in), .rdata2_in(rdata2_in), .muxout_in(muxout_in),
    .valid_out(valid_out), .wb_out(wb_out), .branch_out(branch_out),
    .memread_out(memread_out), .memwrite_out(memwrite_out),
    .add_result_out(add_result_out), .zero_out(zero_out),
    .alu_result_out(alu_result_out), .rdata2_out(rdata2_out),
    .muxout_out(muxout_out), .pcsrc(pcsrc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] wb, input logic [2:0] m,
                       input logic [31:0] add, input logic z, input logic [31:0] alu,
                       input logic [31:0] rd2, input logic [4:0] mux);
    valid_in = v; wb_in = wb; m_in = m; add_result_in = add; zero_in = z;
    alu_result_in = alu; rdata2_in = rd2; muxout_in = mux;
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compares every output; control expectations are packed as {valid, wb[1:0], br, mr, mw, zero, pcsrc}.
  task automatic check_all(input string tag, input logic [7:0] ctl, input logic [31:0] add,
                           input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] mux);
    check({tag, ".valid"},    64'(valid_out),      64'(ctl[7]));
    check({tag, ".wb"},       64'(wb_out),         64'(ctl[6:5]));
    check({tag, ".branch"},   64'(branch_out),     64'(ctl[4]));
    check({tag, ".memread"},  64'(memread_out),    64'(ctl[3]));
    check({tag, ".memwrite"}, 64'(memwrite_out),   64'(ctl[2]));
    check({tag, ".zero"},     64'(zero_out),       64'(ctl[1]));
    check({tag, ".pcsrc"},    64'(pcsrc),          64'(ctl[0]));
    check({tag, ".add"},      64'(add_result_out), 64'(add));
    check({tag, ".alu"},      64'(alu_result_out), 64'(alu));
    check({tag, ".rdata2"},   64'(rdata2_out),     64'(rd2));
    check({tag, ".muxout"},   64'(muxout_out),     64'(mux));
  endtask

  initial begin
    stall = 1'b0; flush = 1'b0; rst = 1'b1;
    drive(1'b1, 2'b11, 3'b111, 32'h1234_5678, 1'b1, 32'hCAFE_F00D, 32'h0BAD_F00D, 5'b11011);

    // Reset held for two edges with all inputs non-zero.
    tick();
    check_all("rst1", 8'b0000_0000, 32'h0, 32'h0, 32'h0, 5'b0);
    tick();
    check_all("rst2", 8'b0000_0000, 32'h0, 32'h0, 32'h0, 5'b0);

    // Release reset with inputs held: everything passes through, branch taken.
    rst = 1'b0;
    tick();
    check_all("rel", 8'b1111_1111, 32'h1234_5678, 32'hCAFE_F00D, 32'h0BAD_F00D, 5'b11011);

    // Normal load.
    drive(1'b1, 2'b10, 3'b000, 32'h0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 5'b10101);
    tick();
    check_all("load", 8'b1100_0000, 32'h0, 32'h0000_0010, 32'hDEAD_BEEF, 5'b10101);

    // Branch taken, then not taken because zero is clear.
    drive(1'b1, 2'b00, 3'b100, 32'h0000_0040, 1'b1, 32'h0, 32'h0, 5'b00000);
    tick();
    check_all("br_taken", 8'b1001_0011, 32'h0000_0040, 32'h0, 32'h0, 5'b0);
    zero_in = 1'b0;
    tick();
    check_all("br_nz", 8'b1001_0000, 32'h0000_0040, 32'h0, 32'h0, 5'b0);

    // memread only maps to the middle m bit.
    drive(1'b1, 2'b01, 3'b010, 32'h0, 1'b0, 32'h0000_0100, 32'h0, 5'b00011);
    tick();
    check_all("memread", 8'b1010_1000, 32'h0, 32'h0000_0100, 32'h0, 5'b00011);

    // Stall: a taken branch latched, then held for three cycles against new inputs.
    drive(1'b1, 2'b00, 3'b100, 32'h0000_0080, 1'b1, 32'h0, 32'h0, 5'b01010);
    tick();
    check("stall_pre.mux", 64'(muxout_out), 64'(5'b01010));
    stall = 1'b1;
    drive(1'b0, 2'b11, 3'b011, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b11111);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all($sformatf("stall%0d", i), 8'b1001_0011, 32'h0000_0080, 32'h0, 32'h0, 5'b01010);
    end
    stall = 1'b0;
    valid_in = 1'b1;
    tick();
    check_all("unstall", 8'b1110_1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b11111);

    // Flush overrides a simultaneous stall.
    drive(1'b1, 2'b11, 3'b001, 32'h0000_0004, 1'b1, 32'h0000_0008, 32'h0000_000C, 5'b00111);
    tick();
    check_all("fl_pre", 8'b1110_0110, 32'h0000_0004, 32'h0000_0008, 32'h0000_000C, 5'b00111);
    stall = 1'b1; flush = 1'b1;
    tick();
    check_all("fl_stall", 8'b0000_0000, 32'h0, 32'h0, 32'h0, 5'b0);
    stall = 1'b0; flush = 1'b0;

    // Invalid slot: control gated, data still loaded.
    drive(1'b0, 2'b11, 3'b111, 32'h0000_0020, 1'b1, 32'h0000_0030, 32'h0000_0050, 5'b00101);
    tick();
    check_all("inval", 8'b0000_0010, 32'h0000_0020, 32'h0000_0030, 32'h0000_0050, 5'b00101);

    // X on gated control fields must not escape.
    wb_in = 2'bxx; m_in = 3'bxxx;
    tick();
    check("inval_x.wb", 64'(wb_out), 64'(2'b00));
    check("inval_x.mw", 64'(memwrite_out), 64'(1'b0));
    check("inval_x.pcsrc", 64'(pcsrc), 64'(1'b0));

    // X data under flush produces a clean bubble.
    muxout_in = 5'bxxxxx; alu_result_in = 'x; flush = 1'b1; valid_in = 1'b1;
    tick();
    check_all("flush_x", 8'b0000_0000, 32'h0, 32'h0, 32'h0, 5'b0);
    flush = 1'b0;

    // Register index 0 passes through untouched.
    drive(1'b1, 2'b10, 3'b000, 32'h0, 1'b0, 32'h0000_0001, 32'h0, 5'b00000);
    tick();
    check_all("reg0", 8'b1100_0000, 32'h0, 32'h0000_0001, 32'h0, 5'b0);

    // Reset during a stall discards the held contents.
    drive(1'b1, 2'b11, 3'b100, 32'h0000_00A0, 1'b1, 32'h0000_00B0, 32'h0000_00C0, 5'b10001);
    tick();
    check("rst_stall_pre.pcsrc", 64'(pcsrc), 64'(1'b1));
    stall = 1'b1; rst = 1'b1;
    tick();
    check_all("rst_stall", 8'b0000_0000, 32'h0, 32'h0, 32'h0, 5'b0);
    rst = 1'b0;
    tick();
    check_all("rst_stall_hold", 8'b0000_0000, 32'h0, 32'h0, 32'h0, 5'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
